// File: rtl/imm_ext_pkg.sv
// Shared mode codes for the immediate extension pipeline.
// Mode 5 (BRANCH) is only legal when IMM_EXT_BRANCH_EN is defined.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    MODE_SIGN   = 3'd0,
    MODE_ZERO   = 3'd1,
    MODE_UPPER  = 3'd2,
    MODE_BSIGN  = 3'd3,
    MODE_BZERO  = 3'd4,
    MODE_BRANCH = 3'd5,
    MODE_RSV6   = 3'd6,
    MODE_RSV7   = 3'd7
  } mode_e;

  localparam logic [2:0] RSV_CODE_A = 3'd6;
  localparam logic [2:0] RSV_CODE_B = 3'd7;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; reserved modes give zero plus err.
// Mode 5 decodes as BRANCH only under IMM_EXT_BRANCH_EN.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  mode_e mode;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] bsext;
  logic [OUT_W-1:0] bzext;

  assign mode  = mode_e'(in_mode);
  assign sext  = OUT_W'($signed(in_data));
  assign zext  = OUT_W'(in_data);
  assign bsext = OUT_W'($signed(in_data[7:0]));
  assign bzext = OUT_W'(in_data[7:0]);

  always_comb begin
    out_data = '0;
    out_err  = 1'b0;
    unique case (1'b1)
      (mode == MODE_SIGN):  out_data = sext;
      (mode == MODE_ZERO):  out_data = zext;
      (mode == MODE_UPPER): out_data = zext << (OUT_W - IN_W);
      (mode == MODE_BSIGN): out_data = bsext;
      (mode == MODE_BZERO): out_data = bzext;
`ifdef IMM_EXT_BRANCH_EN
      (mode == MODE_BRANCH): out_data = sext << 2;
`endif
      default: out_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid buffer with error counter.
// Define IMM_EXT_BRANCH_EN to enable mode 5 (BRANCH).
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic             skid_err;
  logic             acc;
  logic             pop;
  logic             load_out;
  logic             skid_nxt;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .in_data (in_data),
    .in_mode (in_mode),
    .out_data(ext_data),
    .out_err (ext_err)
  );

  assign acc      = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign load_out = !out_valid || out_ready;
  // skid drains whenever the output slot frees up
  assign skid_nxt = load_out ? 1'b0 : (skid_valid || acc);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      in_ready   <= 1'b0;
      err_count  <= '0;
    end else begin
      in_ready   <= !skid_nxt;
      skid_valid <= skid_nxt;
      if (load_out) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_err   <= skid_err;
        end else if (acc) begin
          out_valid <= 1'b1;
          out_data  <= ext_data;
          out_err   <= ext_err;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_data <= ext_data;
        skid_err  <= ext_err;
      end
      if (pop && out_err && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe with a reference extension model.
// Honours IMM_EXT_BRANCH_EN in the model the same way as the design.
module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  in_mode = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [7:0]  err_count;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_data;
  logic [1:0]  s_err_count;

  logic [32:0] sb[$];
  int checks = 0;
  int errors = 0;
  int total  = 0;
  bit lat_pend = 0;
  logic rst_q = 1'b0;

  always #5 Clk = ~Clk;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(8)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .err_count(err_count)
  );

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) u_sat (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_err(s_out_err),
    .err_count(s_err_count)
  );

  function automatic logic [32:0] ref_ext(input logic [15:0] d,
                                          input logic [2:0] m);
    longint u, s, b, sb8, r;
    bit e;
    u = longint'(d);
    s = (u >= 32768) ? u - 65536 : u;
    b = u % 256;
    sb8 = (b >= 128) ? b - 256 : b;
    e = 0;
    r = 0;
    case (m)
      3'd0: r = s;
      3'd1: r = u;
      3'd2: r = u * 65536;
      3'd3: r = sb8;
      3'd4: r = b;
`ifdef IMM_EXT_BRANCH_EN
      3'd5: r = s * 4;
`endif
      default: begin r = 0; e = 1; end
    endcase
    return {e, r[31:0]};
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] d,
                     input logic [2:0] m, input bit r);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    @(negedge Clk);
    if (!Rst && in_valid && in_ready) sb.push_back(ref_ext(d, m));
    @(posedge Clk);
    #1;
  endtask

  always @(posedge Clk) rst_q <= Rst;

  always @(negedge Clk) begin
    logic [32:0] exp;
    if (rst_q) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_sat_in_ready", s_in_ready, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_out_data", {out_err, out_data}, 0);
      sb.delete();
      total = 0;
      lat_pend = 0;
    end else if (!Rst) begin
      if (lat_pend) chk("latency", out_valid, 1);
      chk("err_count", err_count, (total > 255) ? 255 : total);
      chk("err_count_sat", s_err_count, (total > 3) ? 3 : total);
      lat_pend = in_valid && in_ready && (!out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", {out_err, out_data}, 33'h1_dead_beef);
        end else begin
          exp = sb.pop_front();
          chk("out", {out_err, out_data}, exp);
          chk("sat_out", {s_out_valid, s_out_err, s_out_data}, {1'b1, exp});
          if (exp[32]) total++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("rdy_low_before_edge", in_ready, 0);
    cyc(0, 0, 0, 1);
    chk("rdy_after_rst", in_ready, 1);

    cyc(1, 16'h8001, 3'd0, 1);
    cyc(1, 16'h8001, 3'd1, 1);
    cyc(1, 16'h1234, 3'd2, 1);
    cyc(1, 16'h00F0, 3'd3, 1);
    cyc(1, 16'h00F0, 3'd4, 1);
    repeat (2) cyc(0, 0, 0, 1);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'($urandom), 3'(i), 1);
      chk("b2b_rdy", in_ready, 1);
      chk("b2b_valid", out_valid, 1);
    end
    repeat (2) cyc(0, 0, 0, 1);

    cyc(1, 16'hAAAA, 3'd0, 0);
    chk("hold_rdy1", in_ready, 1);
    cyc(1, 16'h5555, 3'd1, 0);
    chk("hold_rdy2", in_ready, 0);
    cyc(1, 16'h0F0F, 3'd2, 0);
    chk("hold_rdy3", in_ready, 0);
    chk("hold_data", out_data, 32'hFFFF_AAAA);
    repeat (3) cyc(0, 0, 0, 1);

    cyc(1, 16'h1234, 3'd6, 1);
    cyc(1, 16'h1234, 3'd7, 1);
    repeat (2) cyc(0, 0, 0, 1);
    chk("err_cnt_two", err_count, 2);
    for (int i = 0; i < 5; i++) cyc(1, 16'($urandom), 3'(6 + (i % 2)), 1);
    repeat (2) cyc(0, 0, 0, 1);
    chk("err_cnt_seven", err_count, 7);
    chk("err_cnt_sat", s_err_count, 3);

    cyc(1, 16'hFFFF, 3'd5, 1);
    repeat (2) cyc(0, 0, 0, 1);

    cyc(1, 16'h1111, 3'd0, 0);
    cyc(1, 16'h2222, 3'd1, 0);
    chk("full_rdy", in_ready, 0);
    Rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 0);
    Rst = 1'b0;
    cyc(0, 0, 0, 1);
    chk("post_rst_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      chk("no_stale", out_valid, 0);
    end

    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, 16'($urandom), 3'($urandom % 8),
          ($urandom % 4) != 0);
    repeat (4) cyc(0, 0, 0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal range 8..OUT_W.
REQ-002 Parameter OUT_W, default 32, extended output width; SHALL be >= IN_W.
REQ-003 Parameter CNT_W, default 8, width of the saturating error counter.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  producer has an immediate this cycle.
REQ-007 in_ready  output  1  block accepts an immediate this cycle.
REQ-008 in_data  input  IN_W  raw immediate field.
REQ-009 in_mode  input  3  extension mode code, see REQ-014.
REQ-010 out_valid  output  1  out_data/out_err hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  OUT_W  extended immediate.
REQ-013 out_err  output  1  result came from a reserved mode; err_count  output  CNT_W  saturating count of reserved-mode transfers.

Function
REQ-014 Modes SHALL be:
- 0 SIGN: {replicated in_data[IN_W-1], in_data}.
- 1 ZERO: {zeros, in_data}.
- 2 UPPER: {in_data, (OUT_W-IN_W) zeros}; when OUT_W==IN_W this equals in_data.
- 3 BSIGN: sign-extend in_data[7:0] to OUT_W.
- 4 BZERO: zero-extend in_data[7:0] to OUT_W.
- 5 BRANCH: see REQ-028.
- 6, 7: reserved.
REQ-015 Reserved modes SHALL produce out_data=0 and out_err=1; all other modes SHALL produce out_err=0.
REQ-016 A transfer SHALL occur on any edge where in_valid && in_ready; the result SHALL appear on out_valid/out_data exactly 1 cycle later if the output stage was empty or drained that cycle.
REQ-017 Buffering SHALL be a 2-entry skid: an output register plus one skid register; in_ready SHALL be a registered signal equal to "skid register empty".
REQ-018 With out_ready held high and in_valid held high, throughput SHALL be 1 result per cycle with no bubbles.
REQ-019 When out_valid && !out_ready, out_data and out_err SHALL hold stable; an accepted input SHALL go to the skid register and in_ready SHALL drop on the next cycle.
REQ-020 When the output is consumed while the skid is full, the skid entry SHALL move to the output register and in_ready SHALL rise on the next cycle; order SHALL be strictly FIFO.
REQ-021 Simultaneous accept and consume with the skid empty SHALL load the new result directly into the output register, with out_valid staying 1.
REQ-022 err_count SHALL increment when a reserved-mode result is consumed (out_valid && out_ready && out_err) and SHALL saturate at all-ones.
REQ-023 in_data/in_mode SHALL be ignored when the transfer condition is false.

Reset
REQ-024 While Rst is high: out_valid=0, out_data=0, out_err=0, err_count=0, skid empty, in_ready=0.
REQ-025 in_ready SHALL be 1 on the first cycle after Rst deasserts.
REQ-026 Rst asserted mid-operation SHALL discard both buffered entries, with no partial output.

Configuration
REQ-027 Macro IMM_EXT_BRANCH_EN SHALL gate mode 5.
REQ-028 With the macro defined, mode 5 SHALL produce SIGN-mode result shifted left 2, low 2 bits zero, upper bits truncated to OUT_W, with out_err=0. Without it, mode 5 SHALL behave as reserved per REQ-015.

Structure
REQ-029 Shared package imm_ext_pkg SHALL hold the mode enum/localparams (MODE_SIGN..MODE_BRANCH) and the reserved-code constants.
REQ-030 The combinational extend function SHALL be the sub-module imm_ext_core; imm_extend_pipe SHALL hold only the skid, handshake and counter logic.

Verification
REQ-031 The bench SHALL cover these directed scenarios (IN_W=16, OUT_W=32):
- SIGN 0x8001 -> 0xFFFF8001; ZERO 0x8001 -> 0x00008001; UPPER 0x1234 -> 0x12340000; BSIGN 0x00F0 -> 0xFFFFFFF0; BZERO 0x00F0 -> 0x000000F0, each 1 cycle after accept.
- Back-to-back 4 transfers with out_ready=1 -> 4 consecutive out_valid cycles, in_ready never low.
- out_ready=0 for 3 cycles with in_valid=1 -> 2 entries held, in_ready=0 from cycle 2, order preserved on release.
- Mode 6 then 7 consumed -> out_data=0, out_err=1, err_count=2; with CNT_W=2, 5 reserved transfers -> err_count=3.
- Mode 5 on 0xFFFF -> 0xFFFFFFFC with IMM_EXT_BRANCH_EN defined; out_data=0, out_err=1 without it.
- Rst pulsed while skid full -> out_valid=0, in_ready=0 during reset, in_ready=1 the next cycle, no stale output.
